mpi_vc_endpoint: RTL and testbench
==================================

# mpi_vc_endpoint

Multi-virtual-channel message-passing endpoint for one NoC port. Each of VCHANNELS channels has a store-and-forward egress packet buffer and an ingress packet buffer, each SIZE flits deep. Software accesses them through a generic single-cycle bus slave. It is the next-generation successor to the single-channel MPI buffer endpoint and sits between the tile bus decoder and the NoC router port. Channel egress is round-robin arbitrated at packet granularity.

## Interface
- NOC_FLIT_WIDTH, 32: flit width; must equal 32, the bus data width; elaboration asserts this.
- SIZE, 16: flits per buffer, per channel and direction; range 2..255.
- VCHANNELS, 2: virtual channels; range 1..8.
- clk  in  1  single clock; everything is synchronous to its rising edge.
- rst  in  1  asynchronous, active-low reset.
- noc_out_flit  out  NOC_FLIT_WIDTH  egress flit; shared by all channels.
- noc_out_last  out  1  last flit of the egress packet.
- noc_out_valid  out  VCHANNELS  per-channel valid; at most one bit is set at a time.
- noc_out_ready  in  VCHANNELS  per-channel ready.
- noc_in_flit  in  NOC_FLIT_WIDTH  ingress flit.
- noc_in_last  in  1  last flit of the ingress packet.
- noc_in_valid  in  VCHANNELS  per-channel valid.
- noc_in_ready  out  VCHANNELS  per-channel ready; bit c is high when ingress buffer c is not full.
- bus_addr  in  32  byte address.
- bus_we  in  1  write enable.
- bus_en  in  1  access strobe, already qualified by the upstream block select.
- bus_data_in  in  32  write data.
- bus_data_out  out  32  read data.
- bus_ack  out  1  access completed.
- bus_err  out  1  access rejected; a rejected access has no side effects.
- irq  out  1  level interrupt.

## Operation
Address decode:
- Channel number c = bus_addr[5 +: clog2(VCHANNELS)]; register r = bus_addr[4:2].
- The access is an error when c ≥ VCHANNELS, when bus_addr[1:0] ≠ 0, or when r is undefined.

Per-channel registers (offset c*0x20 + r):
- 0x00 SEND (W): pushes bus_data_in into egress buffer c with last=0.
- 0x04 SEND_LAST (W): pushes a flit with last=1 and commits the packet (egress packet count +1).
- 0x08 RECV (R): pops the ingress buffer head of channel c and returns the flit.
- 0x0C STATUS (R): [7:0] ingress flit count, [15:8] ingress packet count, [23:16] egress free slots, [24] ingress head flit is last, [25] channel c currently granted on egress, [31:26] zero.
- 0x10 CTRL (RW): bit0 irq_en. Writing 1 to bit1 flushes both buffers and clears all counts of channel c. Bit1 reads as 0.

Error conditions (bus_err instead of bus_ack):
- SEND or SEND_LAST to a full egress buffer.
- RECV from an empty ingress buffer; bus_data_out is 0 in that case.
- Read of SEND or SEND_LAST, or write of RECV or STATUS.
- Flush of a channel whose egress is currently granted.

Egress:
- A channel is eligible when its committed-packet count is nonzero.
- The arbiter grants one eligible channel, round-robin, and holds the grant until the last flit is handshaken.
- After a packet completes on channel g, search starts from channel (g+1) mod VCHANNELS.
- Uncommitted flits are never presented on the NoC.
- A packet longer than SIZE fills the buffer and the bus returns err; software must then flush the channel.

Ingress:
- A flit is accepted when noc_in_valid[c] and noc_in_ready[c] are both high.
- The ingress packet count increments when an accepted flit has last=1.
- The count decrements when RECV pops a flit that has last=1.

irq = OR over c of (irq_en[c] AND ingress packet count[c] ≠ 0).

Simultaneous events on one channel:
- NoC push and RECV pop in the same cycle are both performed; counts change by the net amount.
- SEND_LAST commit and the last egress flit leaving in the same cycle leave the packet count unchanged.

## Timing
- Bus: bus_ack, bus_err and bus_data_out are combinational in the cycle bus_en is high. The state update happens at that cycle's rising edge. bus_ack = bus_err = 0 whenever bus_en = 0.
- Reset values: noc_out_valid = 0; noc_out_last = 0; noc_out_flit = 0; irq = 0; all buffers empty; irq_en = 0; round-robin pointer = 0.
- noc_in_ready goes to all ones in the first cycle after reset is released.
- Reset asserted mid-packet drops noc_out_valid immediately (asynchronously) and discards all buffer contents.
- Commit-to-NoC latency: SEND_LAST at edge k gives noc_out_valid high in cycle k+1 if the arbiter is idle.
- Egress throughput is one flit per cycle while ready is held high. noc_out_valid never deasserts mid-packet.
- Ingress to interrupt: last flit accepted at edge k gives irq high from cycle k+1, if irq_en is set.

## Structure
- Package mpi_pkg: register offsets, STATUS field positions and the CTRL bit positions.
- Sub-module mpi_packet_fifo, instantiated 2×VCHANNELS times. It is a flit+last FIFO with flit count, packet count, and push, pop and flush ports.
- The round-robin arbiter and the address decode live in the top level.

## Test plan
- Write 3×SEND plus 1×SEND_LAST of 0xA0..0xA3 on ch0 → no valid before the commit. noc_out_valid = 01 for 4 consecutive cycles with ready held high; noc_out_last only on 0xA3.
- Commit packets on ch0 and ch1 in the same cycle window, with ch0 re-committed during transfer → grant order ch0, ch1, ch0.
- Drive a 2-flit packet into ingress ch1 (0x11, 0x22 last) with irq_en[1] = 1 → irq high the cycle after the last flit. STATUS[15:0] = 0x0102. RECV ×2 returns 0x11 then 0x22; irq drops after the second pop; a third RECV gives err with data 0.
- Fill ch0 egress with SIZE SEND writes → the next SEND gives err. Flush → STATUS[23:16] = SIZE.
- Flush ch0 while it is granted → err, transfer completes. Access with c = VCHANNELS, or with bus_addr[1:0] = 2 → err.
- Assert rst mid-egress → noc_out_valid = 0 at once. After release: STATUS = egress free SIZE, all counts 0.

Source files
------------

// File: rtl/mpi_pkg.sv
// mpi_pkg: register indices (byte offset = index*4 within a 0x20 channel window), STATUS layout, CTRL bits, counter width
package mpi_pkg;
  localparam int CNT_W = 8;
  localparam logic [2:0] REG_SEND      = 3'd0;
  localparam logic [2:0] REG_SEND_LAST = 3'd1;
  localparam logic [2:0] REG_RECV      = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_CTRL      = 3'd4;
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;
  typedef struct packed {
    logic [5:0] zero;
    logic       granted;
    logic       head_last;
    logic [7:0] egress_free;
    logic [7:0] ingress_pkts;
    logic [7:0] ingress_flits;
  } status_t;
endpackage

// File: rtl/mpi_vc_endpoint_if.sv
// mpi_vc_endpoint_if: single-cycle bus; master drives addr/we/en/data_in, slave returns data_out/ack/err
interface mpi_vc_endpoint_if;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic        bus_en;
  logic [31:0] bus_data_in;
  logic [31:0] bus_data_out;
  logic        bus_ack;
  logic        bus_err;
  modport master (output bus_addr, bus_we, bus_en, bus_data_in, input bus_data_out, bus_ack, bus_err);
  modport slave (input bus_addr, bus_we, bus_en, bus_data_in, output bus_data_out, bus_ack, bus_err);
endinterface

// File: rtl/mpi_packet_fifo.sv
// mpi_packet_fifo: flit+last FIFO with flit/packet counts; ports clk, rst(async low), push/pop/flush in, head flit/last, counts, full out
module mpi_packet_fifo
  import mpi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_flit,
  input  logic             push_last,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_flit,
  output logic             head_last,
  output logic [CNT_W-1:0] flit_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             full
);
  localparam int AW = $clog2(SIZE);
  logic [WIDTH:0] mem [SIZE];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(SIZE - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = flit_cnt == CNT_W'(SIZE);
  assign do_push = push && !full;
  assign do_pop = pop && flit_cnt != '0;
  assign {head_last, head_flit} = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      flit_cnt <= '0;
      pkt_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      flit_cnt <= '0;
      pkt_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      flit_cnt <= flit_cnt + CNT_W'(do_push) - CNT_W'(do_pop);
      pkt_cnt <= pkt_cnt + CNT_W'(do_push && push_last) - CNT_W'(do_pop && head_last);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= {push_last, push_flit};
endmodule

// File: rtl/mpi_vc_endpoint.sv
// mpi_vc_endpoint: multi-VC NoC message endpoint; clk, rst(async low), bus slave, noc_out_* egress (round-robin per packet), noc_in_* ingress, irq
module mpi_vc_endpoint
  import mpi_pkg::*;
#(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int SIZE           = 16,
  parameter int VCHANNELS      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  mpi_vc_endpoint_if.slave          bus,
  output logic [NOC_FLIT_WIDTH-1:0] noc_out_flit,
  output logic                      noc_out_last,
  output logic [VCHANNELS-1:0]      noc_out_valid,
  input  logic [VCHANNELS-1:0]      noc_out_ready,
  input  logic [NOC_FLIT_WIDTH-1:0] noc_in_flit,
  input  logic                      noc_in_last,
  input  logic [VCHANNELS-1:0]      noc_in_valid,
  output logic [VCHANNELS-1:0]      noc_in_ready,
  output logic                      irq
);
  localparam int CW = VCHANNELS > 1 ? $clog2(VCHANNELS) : 1;
  if (NOC_FLIT_WIDTH != 32 || SIZE < 2 || SIZE > 255 || VCHANNELS < 1 || VCHANNELS > 8) begin : g_param_check
    $error("mpi_vc_endpoint: unsupported parameter set");
  end
  logic [CW-1:0] ch, rr, gnt_q, pick, cur, idx;
  logic [2:0] r;
  logic ch_ok, bad, is_send, err_c, acc, flush_wr, busy, any, cur_v, hs, rdy_en, unused_addr;
  logic [VCHANNELS-1:0] e_last, i_last, e_full, i_full, elig, irq_src, irq_en;
  logic [CNT_W-1:0] e_fcnt [VCHANNELS];
  logic [CNT_W-1:0] e_pcnt [VCHANNELS];
  logic [CNT_W-1:0] i_fcnt [VCHANNELS];
  logic [CNT_W-1:0] i_pcnt [VCHANNELS];
  logic [NOC_FLIT_WIDTH-1:0] e_flit [VCHANNELS];
  logic [NOC_FLIT_WIDTH-1:0] i_flit [VCHANNELS];
  status_t st;
  assign ch = bus.bus_addr[5 +: CW];
  assign r = bus.bus_addr[4:2];
  assign unused_addr = ^bus.bus_addr[31:5+CW];
  if ((1 << CW) == VCHANNELS) begin : g_ch_all
    assign ch_ok = 1'b1;
  end else begin : g_ch_lim
    assign ch_ok = ch < CW'(VCHANNELS);
  end
  assign bad = !ch_ok || bus.bus_addr[1:0] != 2'b00 || r > REG_CTRL;
  assign is_send = r == REG_SEND || r == REG_SEND_LAST;
  assign err_c = bad
    || (is_send && (!bus.bus_we || e_full[ch]))
    || (r == REG_RECV && (bus.bus_we || i_fcnt[ch] == '0))
    || (r == REG_STATUS && bus.bus_we)
    || (r == REG_CTRL && bus.bus_we && bus.bus_data_in[CTRL_FLUSH] && noc_out_valid[ch]);
  assign acc = bus.bus_en && !err_c;
  assign bus.bus_ack = acc;
  assign bus.bus_err = bus.bus_en && err_c;
  assign flush_wr = acc && bus.bus_we && r == REG_CTRL && bus.bus_data_in[CTRL_FLUSH];
  assign st = '{zero: '0, granted: noc_out_valid[ch], head_last: i_last[ch] && i_fcnt[ch] != '0,
                egress_free: CNT_W'(SIZE) - e_fcnt[ch], ingress_pkts: i_pcnt[ch], ingress_flits: i_fcnt[ch]};
  assign bus.bus_data_out = !acc || bus.bus_we ? '0
    : r == REG_RECV   ? i_flit[ch]
    : r == REG_STATUS ? st
    : r == REG_CTRL   ? 32'(irq_en[ch])
    : '0;
  always_comb begin
    pick = rr;
    any = 1'b0;
    idx = '0;
    for (int k = VCHANNELS - 1; k >= 0; k--) begin
      idx = CW'((int'(rr) + k) % VCHANNELS);
      if (elig[idx]) begin
        pick = idx;
        any = 1'b1;
      end
    end
  end
  assign cur = busy ? gnt_q : pick;
  assign cur_v = busy || any;
  assign noc_out_flit = cur_v ? e_flit[cur] : '0;
  assign noc_out_last = cur_v && e_last[cur];
  assign hs = |(noc_out_valid & noc_out_ready);
  assign irq = |(irq_en & irq_src);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy <= 1'b0;
      gnt_q <= '0;
      rr <= '0;
      rdy_en <= 1'b0;
      irq_en <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (acc && bus.bus_we && r == REG_CTRL) irq_en[ch] <= bus.bus_data_in[CTRL_IRQ_EN];
      if (hs && noc_out_last) begin
        busy <= 1'b0;
        rr <= cur == CW'(VCHANNELS - 1) ? '0 : cur + 1'b1;
      end else if (cur_v) begin
        busy <= 1'b1;
        gnt_q <= cur;
      end
    end
  for (genvar c = 0; c < VCHANNELS; c++) begin : g_vc
    logic sel;
    assign sel = ch == CW'(c);
    assign elig[c] = e_pcnt[c] != '0;
    assign irq_src[c] = i_pcnt[c] != '0;
    assign noc_out_valid[c] = cur_v && cur == CW'(c);
    assign noc_in_ready[c] = rdy_en && !i_full[c];
    mpi_packet_fifo #(.WIDTH(NOC_FLIT_WIDTH), .SIZE(SIZE)) u_egress (
      .clk       (clk),
      .rst       (rst),
      .push      (acc && bus.bus_we && is_send && sel),
      .push_flit (bus.bus_data_in),
      .push_last (r == REG_SEND_LAST),
      .pop       (noc_out_valid[c] && noc_out_ready[c]),
      .flush     (flush_wr && sel),
      .head_flit (e_flit[c]),
      .head_last (e_last[c]),
      .flit_cnt  (e_fcnt[c]),
      .pkt_cnt   (e_pcnt[c]),
      .full      (e_full[c])
    );
    mpi_packet_fifo #(.WIDTH(NOC_FLIT_WIDTH), .SIZE(SIZE)) u_ingress (
      .clk       (clk),
      .rst       (rst),
      .push      (noc_in_valid[c] && noc_in_ready[c]),
      .push_flit (noc_in_flit),
      .push_last (noc_in_last),
      .pop       (acc && !bus.bus_we && r == REG_RECV && sel),
      .flush     (flush_wr && sel),
      .head_flit (i_flit[c]),
      .head_last (i_last[c]),
      .flit_cnt  (i_fcnt[c]),
      .pkt_cnt   (i_pcnt[c]),
      .full      (i_full[c])
    );
  end
endmodule

// File: tb/tb_mpi_vc_endpoint.sv
// tb_mpi_vc_endpoint: directed self-checking bench for mpi_vc_endpoint (3 channels, 16-flit buffers)
module tb_mpi_vc_endpoint;
  localparam int SIZE = 16;
  localparam int V = 3;
  localparam logic [1:0] ACK = 2'b10;
  localparam logic [1:0] ERR = 2'b01;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] noc_out_flit, noc_in_flit;
  logic noc_out_last, noc_in_last, irq;
  logic [V-1:0] noc_out_valid, noc_out_ready, noc_in_valid, noc_in_ready;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_v [4];
  logic [31:0] exp_f [4];
  logic [31:0] exp_l [4];
  mpi_vc_endpoint_if bus ();
  mpi_vc_endpoint #(.NOC_FLIT_WIDTH(32), .SIZE(SIZE), .VCHANNELS(V)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .noc_out_flit  (noc_out_flit),
    .noc_out_last  (noc_out_last),
    .noc_out_valid (noc_out_valid),
    .noc_out_ready (noc_out_ready),
    .noc_in_flit   (noc_in_flit),
    .noc_in_last   (noc_in_last),
    .noc_in_valid  (noc_in_valid),
    .noc_in_ready  (noc_in_ready),
    .irq           (irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic access(input string tag, input logic [31:0] addr, input logic we, input logic [31:0] wd,
                        input logic [1:0] exp_ae, input logic [31:0] exp_rd);
    @(negedge clk);
    bus.bus_addr = addr;
    bus.bus_we = we;
    bus.bus_data_in = wd;
    bus.bus_en = 1'b1;
    #1;
    chk({tag, "/ack_err"}, 32'({bus.bus_ack, bus.bus_err}), 32'(exp_ae));
    if (!we) chk({tag, "/rdata"}, bus.bus_data_out, exp_rd);
    @(posedge clk);
    #1;
    bus.bus_en = 1'b0;
    bus.bus_we = 1'b0;
  endtask
  initial begin
    bus.bus_addr = '0;
    bus.bus_we = 1'b0;
    bus.bus_en = 1'b0;
    bus.bus_data_in = '0;
    noc_out_ready = '0;
    noc_in_valid = '0;
    noc_in_flit = '0;
    noc_in_last = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(noc_out_valid), 32'h0);
    chk("rst_last", 32'(noc_out_last), 32'h0);
    chk("rst_flit", noc_out_flit, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("in_ready_after_rst", 32'(noc_in_ready), 32'h7);
    chk("idle_ack_err", 32'({bus.bus_ack, bus.bus_err}), 32'h0);
    // Single packet on ch0: nothing on the NoC until SEND_LAST commits it
    noc_out_ready = 3'b111;
    for (int i = 0; i < 3; i++) access("send_a", 32'h00, 1'b1, 32'hA0 + 32'(i), ACK, 32'h0);
    chk("no_valid_uncommitted", 32'(noc_out_valid), 32'h0);
    access("send_last_a", 32'h04, 1'b1, 32'hA3, ACK, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("pktA_valid", 32'(noc_out_valid), 32'h1);
      chk("pktA_flit", noc_out_flit, 32'hA0 + 32'(i));
      chk("pktA_last", 32'(noc_out_last), 32'(i == 3));
    end
    @(negedge clk);
    #1;
    chk("pktA_done", 32'(noc_out_valid), 32'h0);
    // Round robin: ch0 granted, ch1 committed, ch0 re-committed -> ch0, ch1, ch0
    noc_out_ready = 3'b000;
    access("b0", 32'h00, 1'b1, 32'hB0, ACK, 32'h0);
    access("b1", 32'h04, 1'b1, 32'hB1, ACK, 32'h0);
    access("c0", 32'h24, 1'b1, 32'hC0, ACK, 32'h0);
    access("b2", 32'h04, 1'b1, 32'hB2, ACK, 32'h0);
    access("status_ch0_granted", 32'h0C, 1'b0, 32'h0, ACK, 32'h020D0000);
    access("flush_granted", 32'h10, 1'b1, 32'h2, ERR, 32'h0);
    access("status_ch1_pending", 32'h2C, 1'b0, 32'h0, ACK, 32'h000F0000);
    exp_v = '{32'h1, 32'h1, 32'h2, 32'h1};
    exp_f = '{32'hB0, 32'hB1, 32'hC0, 32'hB2};
    exp_l = '{32'h0, 32'h1, 32'h1, 32'h1};
    @(negedge clk);
    #1;
    noc_out_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      chk("rr_valid", 32'(noc_out_valid), exp_v[i]);
      chk("rr_flit", noc_out_flit, exp_f[i]);
      chk("rr_last", 32'(noc_out_last), exp_l[i]);
      @(negedge clk);
      #1;
    end
    chk("rr_done", 32'(noc_out_valid), 32'h0);
    // Ingress ch1 with interrupt enabled
    access("irq_en1", 32'h30, 1'b1, 32'h1, ACK, 32'h0);
    @(negedge clk);
    noc_in_valid = 3'b010;
    noc_in_flit = 32'h11;
    noc_in_last = 1'b0;
    @(negedge clk);
    noc_in_flit = 32'h22;
    noc_in_last = 1'b1;
    #1;
    chk("irq_before_last", 32'(irq), 32'h0);
    @(negedge clk);
    noc_in_valid = 3'b000;
    noc_in_last = 1'b0;
    #1;
    chk("irq_after_last", 32'(irq), 32'h1);
    access("ctrl1_rd", 32'h30, 1'b0, 32'h0, ACK, 32'h1);
    access("status_ch1_in", 32'h2C, 1'b0, 32'h0, ACK, 32'h00100102);
    access("recv1", 32'h28, 1'b0, 32'h0, ACK, 32'h11);
    chk("irq_mid_pkt", 32'(irq), 32'h1);
    access("recv2", 32'h28, 1'b0, 32'h0, ACK, 32'h22);
    chk("irq_drained", 32'(irq), 32'h0);
    access("recv_empty", 32'h28, 1'b0, 32'h0, ERR, 32'h0);
    // Egress overflow and flush
    noc_out_ready = 3'b000;
    for (int i = 0; i < SIZE; i++) access("fill", 32'h00, 1'b1, 32'(i), ACK, 32'h0);
    chk("fill_no_valid", 32'(noc_out_valid), 32'h0);
    access("overflow", 32'h00, 1'b1, 32'hFF, ERR, 32'h0);
    access("status_full", 32'h0C, 1'b0, 32'h0, ACK, 32'h00000000);
    access("flush_ch0", 32'h10, 1'b1, 32'h2, ACK, 32'h0);
    access("status_flushed", 32'h0C, 1'b0, 32'h0, ACK, 32'h00100000);
    access("ctrl0_rd", 32'h10, 1'b0, 32'h0, ACK, 32'h0);
    // Decode errors
    access("bad_channel", 32'h60, 1'b0, 32'h0, ERR, 32'h0);
    access("misaligned", 32'h02, 1'b0, 32'h0, ERR, 32'h0);
    access("read_send", 32'h00, 1'b0, 32'h0, ERR, 32'h0);
    access("undef_reg", 32'h14, 1'b0, 32'h0, ERR, 32'h0);
    access("write_status", 32'h0C, 1'b1, 32'h0, ERR, 32'h0);
    access("status_after_errs", 32'h0C, 1'b0, 32'h0, ACK, 32'h00100000);
    // Reset in the middle of an egress packet
    access("irq_en0", 32'h10, 1'b1, 32'h1, ACK, 32'h0);
    @(negedge clk);
    noc_in_valid = 3'b001;
    noc_in_flit = 32'h55;
    noc_in_last = 1'b1;
    @(negedge clk);
    noc_in_valid = 3'b000;
    noc_in_last = 1'b0;
    #1;
    chk("irq_ch0", 32'(irq), 32'h1);
    access("d0", 32'h00, 1'b1, 32'hD0, ACK, 32'h0);
    access("d1", 32'h04, 1'b1, 32'hD1, ACK, 32'h0);
    chk("pre_rst_valid", 32'(noc_out_valid), 32'h1);
    chk("pre_rst_flit", noc_out_flit, 32'hD0);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(noc_out_valid), 32'h0);
    chk("async_rst_flit", noc_out_flit, 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", 32'(noc_in_ready), 32'h7);
    chk("post_rst_valid", 32'(noc_out_valid), 32'h0);
    access("post_rst_status0", 32'h0C, 1'b0, 32'h0, ACK, 32'h00100000);
    access("post_rst_status1", 32'h2C, 1'b0, 32'h0, ACK, 32'h00100000);
    access("post_rst_ctrl0", 32'h10, 1'b0, 32'h0, ACK, 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
